rw_context_scheduler: RTL

- Time-multiplexes one combinational resumption step function (a compiled device's next-state/output logic with its tag register removed) across N_CTX independent contexts.
- Holds one resumption tag per context and arbitrates round-robin among requesters.
- Each accepted request performs exactly one device step for the granted context, writes back that context's tag and returns a registered response.
- Sits between the requesting datapaths and the shared step core, replacing the core's private tag flop.

---
 rtl/rw_context_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rw_context_scheduler.sv
// Shares one combinational resumption step core across N_CTX contexts.
// Each context owns a resumption tag and a halt flag. Requesters are served
// round-robin, one step per accepted request, with a registered response.
module rw_context_scheduler #(
  parameter int unsigned N_CTX = 4,
  parameter int unsigned IN_W = 3,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned TAG_W = 5,
  parameter logic [TAG_W-1:0] RESET_TAG = 5'h10,
  localparam int unsigned CTX_W = (N_CTX > 1) ? $clog2(N_CTX) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CTX-1:0]        req_valid,
  output logic [N_CTX-1:0]        req_ready,
  input  logic [N_CTX*IN_W-1:0]   req_data,
  input  logic [N_CTX-1:0]        ctx_restart,
  output logic [N_CTX-1:0]        ctx_halted,
  output logic [IN_W-1:0]         step_in,
  output logic [TAG_W-1:0]        step_tag,
  input  logic                    step_continue,
  input  logic                    step_out0,
  input  logic [OUT_W-1:0]        step_out1,
  input  logic [TAG_W-1:0]        step_tag_next,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [CTX_W-1:0]        resp_ctx,
  output logic                    resp_out0,
  output logic [OUT_W-1:0]        resp_out1,
  output logic                    resp_last,
  output logic [15:0]             step_count
);

  logic [TAG_W-1:0] tag_q [N_CTX];
  logic [N_CTX-1:0] halted_q;
  logic [CTX_W-1:0] ptr_q;
  logic [15:0]      count_q;

  logic             resp_valid_q;
  logic [CTX_W-1:0] resp_ctx_q;
  logic             resp_out0_q;
  logic [OUT_W-1:0] resp_out1_q;
  logic             resp_last_q;

  logic [N_CTX-1:0] eligible;
  logic [CTX_W-1:0] grant_idx;
  logic [CTX_W-1:0] scan_idx;
  logic             grant_valid;
  logic             slot_free;
  logic             accept;

  // A context restarting this cycle is not eligible, so restart always wins.
  assign eligible  = req_valid & ~halted_q & ~ctx_restart;
  assign slot_free = ~resp_valid_q | resp_ready;
  assign accept    = grant_valid & slot_free;

  // Round-robin search: first eligible context at ptr, ptr+1, ... mod N_CTX.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr_q;
    scan_idx    = '0;
    for (int unsigned k = 0; k < N_CTX; k++) begin
      scan_idx = CTX_W'((32'(ptr_q) + k) % N_CTX);
      if (!grant_valid && eligible[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // One-hot ready for the granted context, only when the response slot frees.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // With no grant these still follow ptr; the core output is then ignored.
  assign step_in  = req_data[32'(grant_idx)*IN_W +: IN_W];
  assign step_tag = tag_q[grant_idx];

  // Per-context tag and halt state: step writeback, then restart override.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CTX); i++) begin
        tag_q[i] <= RESET_TAG;
      end
      halted_q <= '0;
    end else begin
      if (accept) begin
        tag_q[grant_idx]    <= step_tag_next;
        halted_q[grant_idx] <= ~step_continue;
      end
      for (int i = 0; i < int'(N_CTX); i++) begin
        if (ctx_restart[i]) begin
          tag_q[i]    <= RESET_TAG;
          halted_q[i] <= 1'b0;
        end
      end
    end
  end

  // Arbitration pointer, step counter and the single-entry response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_ctx_q   <= '0;
      resp_out0_q  <= 1'b0;
      resp_out1_q  <= '0;
      resp_last_q  <= 1'b0;
    end else if (accept) begin
      ptr_q        <= CTX_W'((32'(grant_idx) + 1) % N_CTX);
      count_q      <= count_q + 16'd1;
      resp_valid_q <= 1'b1;
      resp_ctx_q   <= grant_idx;
      resp_out0_q  <= step_out0;
      resp_out1_q  <= step_out1;
      resp_last_q  <= ~step_continue;
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign ctx_halted = halted_q;
  assign resp_valid = resp_valid_q;
  assign resp_ctx   = resp_ctx_q;
  assign resp_out0  = resp_out0_q;
  assign resp_out1  = resp_out1_q;
  assign resp_last  = resp_last_q;
  assign step_count = count_q;

endmodule
